// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencing controller.
package alu_seq_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned RES_W  = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned OCNT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [2:0] OC_NOT = 3'd0;
  localparam logic [2:0] OC_AND = 3'd1;
  localparam logic [2:0] OC_OR  = 3'd2;
  localparam logic [2:0] OC_XOR = 3'd3;
  localparam logic [2:0] OC_ADD = 3'd4;
  localparam logic [2:0] OC_SUB = 3'd5;
  localparam logic [2:0] OC_NEG = 3'd6;
  localparam logic [2:0] OC_MUL = 3'd7;

  localparam int unsigned FLG_CRY   = 7;
  localparam int unsigned FLG_BRR   = 6;
  localparam int unsigned FLG_ZRO   = 5;
  localparam int unsigned FLG_NEG   = 4;
  localparam int unsigned FLG_ARITH = 3;
  localparam int unsigned FLG_EQ    = 2;
  localparam int unsigned FLG_GTR   = 1;
  localparam int unsigned FLG_MIN   = 0;

  // Field order matches the FLG_* bit indices (cry in bit 7, min in bit 0).
  typedef struct packed {
    logic cry;
    logic brr;
    logic zro;
    logic neg;
    logic arith;
    logic eq;
    logic gtr;
    logic min;
  } flags_t;

  function automatic flags_t pack_flags(
    input logic cry, input logic brr, input logic zro, input logic neg,
    input logic arith, input logic eq, input logic gtr, input logic min
  );
    flags_t f;
    f.cry   = cry;
    f.brr   = brr;
    f.zro   = zro;
    f.neg   = neg;
    f.arith = arith;
    f.eq    = eq;
    f.gtr   = gtr;
    f.min   = min;
    return f;
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Sequencer in front of a combinational 4-bit ALU: registers operands, waits a
// settle time, captures result/flags, and keeps an accumulator for chaining.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_oc,
  input  logic [DATA_W-1:0]   cmd_a,
  input  logic [DATA_W-1:0]   cmd_b,
  input  logic                cmd_use_acc,
  input  logic                cmd_use_cry,
  input  logic                acc_clr,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [2:0]          alu_oc,
  output logic                alu_cry_in,
  input  logic [RES_W-1:0]    alu_c,
  input  logic                alu_cry,
  input  logic                alu_brr,
  input  logic                alu_zro,
  input  logic                alu_neg,
  input  logic                alu_arith,
  input  logic                alu_eq,
  input  logic                alu_gtr,
  input  logic                alu_min,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [RES_W-1:0]    rsp_c,
  output logic [7:0]          rsp_flags,
  output logic [OCNT_W-1:0]   op_count
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_capture;
  logic                w_rsp_hs;
  logic                r_cmd_ready;
  logic                r_rsp_valid;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [2:0]          r_alu_oc;
  logic                r_alu_cry_in;
  logic [RES_W-1:0]    r_rsp_c;
  flags_t              r_rsp_flags;
  flags_t              w_flags;
  // Only the low nibble of the accumulator is ever fed back as an operand.
  logic [DATA_W-1:0]   r_acc;
  logic                r_cry;
  logic [OCNT_W-1:0]   r_op_count;

  assign w_flags = pack_flags(alu_cry, alu_brr, alu_zro, alu_neg,
                              alu_arith, alu_eq, alu_gtr, alu_min);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and per-edge strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_rsp_hs    = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (r_cnt == CNT_LAST) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (r_rsp_valid && rsp_ready) begin
          w_rsp_hs    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      r_cmd_ready <= (w_state_nxt == IDLE);
      r_rsp_valid <= (w_state_nxt == RESP);
    end
  end

  // ALU drive registers hold for the whole command; settle countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_oc     <= '0;
      r_alu_cry_in <= 1'b0;
      r_cnt        <= '0;
    end else if (w_accept) begin
      r_alu_a      <= cmd_use_acc ? r_acc : cmd_a;
      r_alu_b      <= cmd_b;
      r_alu_oc     <= cmd_oc;
      r_alu_cry_in <= cmd_use_cry & r_cry;
      r_cnt        <= CNT_LOAD;
    end else if (r_state == SETTLE) begin
      r_cnt        <= r_cnt - CNT_W'(1);
    end
  end

  // Response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_c     <= '0;
      r_rsp_flags <= '0;
    end else if (w_capture) begin
      r_rsp_c     <= alu_c;
      r_rsp_flags <= w_flags;
    end
  end

  // Accumulator and carry; a coincident clear overrides the capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cry <= 1'b0;
    end else if (acc_clr) begin
      r_acc <= '0;
      r_cry <= 1'b0;
    end else if (w_capture) begin
      r_acc <= alu_c[DATA_W-1:0];
      r_cry <= alu_cry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_op_count <= '0;
    else if (w_rsp_hs) r_op_count <= r_op_count + OCNT_W'(1);
  end

  assign cmd_ready  = r_cmd_ready;
  assign rsp_valid  = r_rsp_valid;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_oc     = r_alu_oc;
  assign alu_cry_in = r_alu_cry_in;
  assign rsp_c      = r_rsp_c;
  assign rsp_flags  = r_rsp_flags;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a default-settle instance drives a vector
// table plus hand sequences; a SETTLE_CYCLES=4 instance covers long settle.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       cmd_valid, cmd4_valid, rsp_ready, rsp4_ready;
  logic [2:0] cmd_oc;
  logic [3:0] cmd_a, cmd_b;
  logic       cmd_use_acc, cmd_use_cry, acc_clr;

  logic       cmd_ready, rsp_valid, alu_cry_in;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_oc;
  logic [7:0] alu_c, rsp_c, rsp_flags;
  logic [15:0] op_count;
  logic alu_cry, alu_brr, alu_zro, alu_neg, alu_arith, alu_eq, alu_gtr, alu_min;

  logic       cmd4_ready, rsp4_valid, alu4_cry_in;
  logic [3:0] alu4_a, alu4_b;
  logic [2:0] alu4_oc;
  logic [7:0] alu4_c, rsp4_c, rsp4_flags;
  logic [15:0] op4_count;
  logic a4_cry, a4_brr, a4_zro, a4_neg, a4_arith, a4_eq, a4_gtr, a4_min;

  int n_chk = 0;
  int n_err = 0;

  // Reference 4-bit ALU: returns {result, flags} with flags in FLG_* order.
  function automatic logic [15:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                            input logic [2:0] oc, input logic cin);
    logic [7:0] c;
    logic [7:0] f;
    logic [4:0] t;
    c = '0; f = '0; t = '0;
    case (oc)
      OC_NOT: c = {4'h0, ~a};
      OC_AND: c = {4'h0, a & b};
      OC_OR:  c = {4'h0, a | b};
      OC_XOR: c = {4'h0, a ^ b};
      OC_ADD: begin
        t = {1'b0, a} + {1'b0, b} + {4'h0, cin};
        c = {3'h0, t};
        f[FLG_CRY] = t[4];
      end
      OC_SUB: begin
        t = {1'b0, a} - {1'b0, b} - {4'h0, cin};
        c = {4'h0, t[3:0]};
        f[FLG_BRR] = t[4];
      end
      OC_NEG: begin
        t = 5'h0 - {1'b0, a};
        c = {4'h0, t[3:0]};
      end
      default: c = {4'h0, a} * {4'h0, b};
    endcase
    f[FLG_ZRO]   = (c == 8'h00);
    f[FLG_NEG]   = (oc == OC_MUL) ? c[7] : c[3];
    f[FLG_ARITH] = oc[2];
    f[FLG_EQ]    = (a == b);
    f[FLG_GTR]   = (a > b);
    f[FLG_MIN]   = (a < b);
    return {c, f};
  endfunction

  always_comb {alu_c, alu_cry, alu_brr, alu_zro, alu_neg, alu_arith, alu_eq, alu_gtr, alu_min}
    = alu_model(alu_a, alu_b, alu_oc, alu_cry_in);
  always_comb {alu4_c, a4_cry, a4_brr, a4_zro, a4_neg, a4_arith, a4_eq, a4_gtr, a4_min}
    = alu_model(alu4_a, alu4_b, alu4_oc, alu4_cry_in);

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_oc(cmd_oc),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .cmd_use_cry(cmd_use_cry),
    .acc_clr(acc_clr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_oc(alu_oc), .alu_cry_in(alu_cry_in),
    .alu_c(alu_c), .alu_cry(alu_cry), .alu_brr(alu_brr), .alu_zro(alu_zro),
    .alu_neg(alu_neg), .alu_arith(alu_arith), .alu_eq(alu_eq), .alu_gtr(alu_gtr),
    .alu_min(alu_min),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c), .rsp_flags(rsp_flags),
    .op_count(op_count)
  );

  alu_sequencer #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd4_valid), .cmd_ready(cmd4_ready), .cmd_oc(cmd_oc),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .cmd_use_cry(cmd_use_cry),
    .acc_clr(acc_clr),
    .alu_a(alu4_a), .alu_b(alu4_b), .alu_oc(alu4_oc), .alu_cry_in(alu4_cry_in),
    .alu_c(alu4_c), .alu_cry(a4_cry), .alu_brr(a4_brr), .alu_zro(a4_zro),
    .alu_neg(a4_neg), .alu_arith(a4_arith), .alu_eq(a4_eq), .alu_gtr(a4_gtr),
    .alu_min(a4_min),
    .rsp_valid(rsp4_valid), .rsp_ready(rsp4_ready), .rsp_c(rsp4_c), .rsp_flags(rsp4_flags),
    .op_count(op4_count)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One command through the default instance; starts and ends on a falling edge.
  task automatic run_cmd(input string nm, input logic [2:0] oc, input logic [3:0] a,
                         input logic [3:0] b, input logic ua, input logic uc,
                         input logic clr_acc, input logic clr_cap,
                         input logic [3:0] ea, input logic ec,
                         input logic [7:0] exp_c, input logic [7:0] exp_f);
    chk({nm, ".ready"}, 16'(cmd_ready), 16'h1);
    cmd_oc = oc; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_use_cry = uc;
    cmd_valid = 1'b1; rsp_ready = 1'b1; acc_clr = clr_acc;
    @(negedge clk);
    cmd_valid = 1'b0; acc_clr = clr_cap;
    chk({nm, ".alu_a"}, 16'(alu_a), 16'(ea));
    chk({nm, ".cry_in"}, 16'(alu_cry_in), 16'(ec));
    chk({nm, ".early_valid"}, 16'(rsp_valid), 16'h0);
    @(negedge clk);
    acc_clr = 1'b0;
    chk({nm, ".rsp_valid"}, 16'(rsp_valid), 16'h1);
    chk({nm, ".rsp_c"}, 16'(rsp_c), 16'(exp_c));
    chk({nm, ".rsp_flags"}, 16'(rsp_flags), 16'(exp_f));
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0] oc;
    logic [3:0] a, b;
    logic       ua, uc;
    logic [3:0] ea;
    logic       ec;
    logic [7:0] c, f;
  } vec_t;

  vec_t vt[12];

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Accumulator/carry chain across consecutive rows is part of each expectation.
    vt[0]  = '{OC_ADD, 4'h5, 4'h3, 1'b0, 1'b0, 4'h5, 1'b0, 8'h08, 8'h1A};
    vt[1]  = '{OC_ADD, 4'h9, 4'h9, 1'b0, 1'b0, 4'h9, 1'b0, 8'h12, 8'h8C};
    vt[2]  = '{OC_ADD, 4'hF, 4'h1, 1'b1, 1'b1, 4'h2, 1'b1, 8'h04, 8'h0A};
    vt[3]  = '{OC_SUB, 4'h3, 4'h5, 1'b0, 1'b1, 4'h3, 1'b0, 8'h0E, 8'h59};
    vt[4]  = '{OC_XOR, 4'h1, 4'hE, 1'b1, 1'b0, 4'hE, 1'b0, 8'h00, 8'h24};
    vt[5]  = '{OC_NOT, 4'h5, 4'h0, 1'b0, 1'b0, 4'h5, 1'b0, 8'h0A, 8'h12};
    vt[6]  = '{OC_NEG, 4'h3, 4'h0, 1'b1, 1'b0, 4'hA, 1'b0, 8'h06, 8'h0A};
    vt[7]  = '{OC_MUL, 4'h9, 4'h3, 1'b1, 1'b0, 4'h6, 1'b0, 8'h12, 8'h0A};
    vt[8]  = '{OC_AND, 4'hC, 4'hA, 1'b0, 1'b0, 4'hC, 1'b0, 8'h08, 8'h12};
    vt[9]  = '{OC_OR,  4'h3, 4'h3, 1'b0, 1'b0, 4'h3, 1'b0, 8'h03, 8'h04};
    vt[10] = '{OC_ADD, 4'hF, 4'h1, 1'b0, 1'b0, 4'hF, 1'b0, 8'h10, 8'h8A};
    vt[11] = '{OC_ADD, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b1, 8'h01, 8'h0C};

    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd4_valid = 1'b0; rsp_ready = 1'b1; rsp4_ready = 1'b1;
    cmd_oc = '0; cmd_a = '0; cmd_b = '0; cmd_use_acc = 1'b0; cmd_use_cry = 1'b0;
    acc_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.cmd_ready", 16'(cmd_ready), 16'h1);
    chk("rst.rsp_valid", 16'(rsp_valid), 16'h0);
    chk("rst.rsp_c", 16'(rsp_c), 16'h0);
    chk("rst.rsp_flags", 16'(rsp_flags), 16'h0);
    chk("rst.alu_ops", 16'({alu_a, alu_b, alu_oc, alu_cry_in}), 16'h0);
    chk("rst.op_count", op_count, 16'h0);
    chk("rst4.cmd_ready", 16'(cmd4_ready), 16'h1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      run_cmd($sformatf("vec%0d", i), vt[i].oc, vt[i].a, vt[i].b, vt[i].ua, vt[i].uc,
              1'b0, 1'b0, vt[i].ea, vt[i].ec, vt[i].c, vt[i].f);
    chk("table.op_count", op_count, 16'd12);

    // Clear on the capture edge: response intact, acc and carry cleared.
    run_cmd("pre_clr", OC_ADD, 4'h9, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 4'h9, 1'b0, 8'h12, 8'h8C);
    run_cmd("clr_cap", OC_ADD, 4'h7, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h7, 1'b0, 8'h08, 8'h1A);
    run_cmd("after_clr", OC_ADD, 4'h5, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 8'h2C);
    run_cmd("cry_cap", OC_ADD, 4'hF, 4'h9, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 8'h18, 8'h9A);
    run_cmd("cry_after", OC_ADD, 4'h1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 1'b0, 8'h02, 8'h0C);
    // Clear coinciding with a use_acc accept still sees the old accumulator.
    run_cmd("acc_set", OC_ADD, 4'h5, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 1'b0, 8'h05, 8'h0A);
    run_cmd("clr_acc", OC_ADD, 4'h0, 4'h1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h5, 1'b0, 8'h06, 8'h0A);

    // Backpressure: response holds and a second command waits.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("bp.op_count0", op_count, 16'h0);
    cmd_oc = OC_ADD; cmd_a = 4'h1; cmd_b = 4'h2; cmd_use_acc = 1'b0; cmd_use_cry = 1'b0;
    cmd_valid = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp.rsp_valid", 16'(rsp_valid), 16'h1);
    cmd_oc = OC_AND; cmd_a = 4'hF; cmd_b = 4'hF; cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp.hold_c", 16'(rsp_c), 16'h03);
      chk("bp.hold_f", 16'(rsp_flags), 16'h09);
      chk("bp.hold_ready", 16'({cmd_ready, rsp_valid}), 16'b01);
      chk("bp.hold_alu_a", 16'(alu_a), 16'h1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp.ready_back", 16'({cmd_ready, rsp_valid}), 16'b10);
    chk("bp.op_count1", op_count, 16'h1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp.second_a", 16'({alu_a, 1'b0, alu_oc}), 16'({4'hF, 1'b0, OC_AND}));
    @(negedge clk);
    chk("bp.second_c", 16'(rsp_c), 16'h0F);
    chk("bp.second_f", 16'(rsp_flags), 16'h14);
    @(negedge clk);

    // Long settle: capture exactly four edges after accept.
    cmd_oc = OC_MUL; cmd_a = 4'hF; cmd_b = 4'hF;
    cmd4_valid = 1'b1;
    @(negedge clk);
    cmd4_valid = 1'b0;
    chk("s4.alu_a", 16'(alu4_a), 16'hF);
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("s4.valid_k%0d", k), 16'(rsp4_valid), (k == 5) ? 16'h1 : 16'h0);
      if (k < 5) @(negedge clk);
    end
    chk("s4.rsp_c", 16'(rsp4_c), 16'hE1);
    chk("s4.rsp_f", 16'(rsp4_flags), 16'h1C);
    @(negedge clk);
    chk("s4.op_count", op4_count, 16'h1);

    // Reset mid-settle discards the command.
    cmd_oc = OC_ADD; cmd_a = 4'h2; cmd_b = 4'h3;
    cmd4_valid = 1'b1;
    @(negedge clk);
    cmd4_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst4.async_valid", 16'({cmd4_ready, rsp4_valid}), 16'b10);
    chk("rst4.async_alu_a", 16'(alu4_a), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst4.after_valid", 16'({cmd4_ready, rsp4_valid}), 16'b10);
    chk("rst4.op_count", op4_count, 16'h0);

    // op_count rollover.
    force dut.r_op_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_op_count;
    run_cmd("wrap", OC_ADD, 4'h5, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 1'b0, 8'h08, 8'h1A);
    chk("wrap.op_count", op_count, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
